// File: rtl/bus_dma_if.sv
// bus_dma_if -- request/status and bus-control signals of the bus_dma block.
//
// Signals
//   start     : transfer request (sampled by the DMA while idle)
//   src_addr  : byte address of the first source word
//   dst_addr  : byte address of the first destination word
//   len       : transfer length in 32-bit words
//   busy      : a transfer currently owns the memory bus
//   done      : one-cycle pulse when a transfer completes
//   err       : one-cycle pulse when a request is rejected
//   mem_we    : bus write strobe (1 = write, 0 = read)
//   mem_addr  : bus byte address
//
// Modports
//   master : the requester side (drives the request, observes status/bus)
//   slave  : the DMA side (accepts the request, drives status/bus control)
//
// The shared bidirectional data bus is a plain inout port on bus_dma so
// that its tri-state resolution stays on a single net at the top level.
interface bus_dma_if;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [10:0] len;
  logic        busy;
  logic        done;
  logic        err;
  logic        mem_we;
  logic [31:0] mem_addr;

  modport master (
    output start, src_addr, dst_addr, len,
    input  busy, done, err, mem_we, mem_addr
  );

  modport slave (
    input  start, src_addr, dst_addr, len,
    output busy, done, err, mem_we, mem_addr
  );
endinterface

// File: rtl/bus_dma.sv
// bus_dma -- single-channel word copy engine acting as initiator on a shared
// memory bus. Each word costs one READ cycle (responder returns data
// combinationally) followed by one WRITE cycle (responder captures on the
// closing edge). Words are copied strictly in ascending order.
//
// Ports
//   clk       : system clock, all state changes on posedge
//   rst       : asynchronous active-high reset
//   bus       : bus_dma_if.slave -- request (start/src_addr/dst_addr/len),
//               status (busy/done/err) and bus control (mem_we/mem_addr)
//   mem_data  : shared 32-bit bidirectional data bus, driven only in WRITE
//
// Parameter
//   ADDR_LIMIT : highest legal byte address on the memory bus
module bus_dma #(
  parameter int ADDR_LIMIT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  bus_dma_if.slave    bus,
  inout  wire  [31:0] mem_data
);

  localparam logic [33:0] LIMIT = 34'(ADDR_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t      state_q, state_d;

  logic [31:0] src_q;
  logic [31:0] dst_q;
  logic [10:0] rem_q;
  logic [31:0] buf_q;

  logic        drive_en;

  // Request legality: the last byte of each range is evaluated at 34 bits so
  // that a range running past 2^32 cannot wrap into a small legal address.
  logic [33:0] len_bytes;
  logic [33:0] src_end;
  logic [33:0] dst_end;
  logic        req_ok;

  assign len_bytes = {21'd0, bus.len, 2'b00};
  assign src_end   = {2'b00, bus.src_addr} + len_bytes - 34'd1;
  assign dst_end   = {2'b00, bus.dst_addr} + len_bytes - 34'd1;

  always_comb begin
    req_ok = (bus.src_addr[1:0] == 2'b00) &&
             (bus.dst_addr[1:0] == 2'b00) &&
             (bus.len != 11'd0) &&
             (src_end <= LIMIT) &&
             (dst_end <= LIMIT);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = req_ok ? S_READ : S_ERR;
        end
      end
      S_READ:  state_d = S_WRITE;
      // rem_q still holds the pre-decrement count here, so 1 means this was
      // the last word.
      S_WRITE: state_d = (rem_q == 11'd1) ? S_DONE : S_READ;
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Transfer registers: address pointers, word counter and the word buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q <= 32'd0;
      dst_q <= 32'd0;
      rem_q <= 11'd0;
      buf_q <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start && req_ok) begin
            src_q <= bus.src_addr;
            dst_q <= bus.dst_addr;
            rem_q <= bus.len;
          end
        end
        S_READ: begin
          buf_q <= mem_data;
        end
        S_WRITE: begin
          src_q <= src_q + 32'd4;
          dst_q <= dst_q + 32'd4;
          rem_q <= rem_q - 11'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode: everything derives from registered state/pointers only,
  // so an asynchronous reset releases the bus without waiting for a clock.
  always_comb begin
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.err      = 1'b0;
    bus.mem_we   = 1'b0;
    bus.mem_addr = 32'd0;
    drive_en     = 1'b0;
    case (state_q)
      S_READ: begin
        bus.busy     = 1'b1;
        bus.mem_addr = src_q;
      end
      S_WRITE: begin
        bus.busy     = 1'b1;
        bus.mem_we   = 1'b1;
        bus.mem_addr = dst_q;
        drive_en     = 1'b1;
      end
      S_DONE:  bus.done = 1'b1;
      S_ERR:   bus.err  = 1'b1;
      default: begin
      end
    endcase
  end

  assign mem_data = drive_en ? buf_q : 32'bz;

endmodule

// File: doc/bus_dma.md
BUS_DMA -- requirements
Module: bus_dma

Interface
REQ-001 Parameter ADDR_LIMIT, default 1023, highest legal byte address on the shared memory bus.
REQ-002 clk  input  1  system clock; all state updates on posedge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  transfer request, sampled on posedge while IDLE.
REQ-005 src_addr  input  32  byte address of first source word.
REQ-006 dst_addr  input  32  byte address of first destination word.
REQ-007 len  input  11  transfer length in 32-bit words.
REQ-008 busy  output  1  high while a transfer occupies the bus.
REQ-009 done  output  1  one-cycle pulse on successful completion.
REQ-010 err  output  1  one-cycle pulse on a rejected request.
REQ-011 mem_we  output  1  bus write strobe (1 = write, 0 = read).
REQ-012 mem_addr  output  32  bus byte address.
REQ-013 mem_data  inout  32  shared bidirectional bus data.

Function
REQ-014 The block shall be the bus initiator: the responder returns read data combinationally in the same cycle (mem_we=0) and captures write data on posedge (mem_we=1).
REQ-015 The FSM shall have states IDLE, READ, WRITE, DONE, ERR; all outputs shall be registered or decoded from registered state only.
REQ-016 In IDLE with start=1, the request shall be checked: src_addr[1:0]==0, dst_addr[1:0]==0, len!=0, src_addr+4*len-1<=ADDR_LIMIT, dst_addr+4*len-1<=ADDR_LIMIT, computed at 34-bit width so that no sum wraps.
REQ-017 A failing check shall go IDLE->ERR (err=1 for one cycle) ->IDLE with no bus activity (mem_we stays 0).
REQ-018 A passing check shall latch src, dst, len into internal registers and go IDLE->READ; inputs are ignored thereafter until return to IDLE.
REQ-019 READ: mem_we=0, mem_addr=current src, mem_data released (high-Z); mem_data shall be captured into a 32-bit word buffer at the closing posedge; next state WRITE.
REQ-020 WRITE: mem_we=1, mem_addr=current dst, mem_data driven with the buffer; at the closing posedge src+=4, dst+=4, remaining-=1; next state READ if remaining>0 after decrement, else DONE.
REQ-021 DONE: done=1 for exactly one cycle, then IDLE.
REQ-022 mem_data shall be driven by this block only while in WRITE; in all other states it shall be high-Z.
REQ-023 busy shall be 1 in READ and WRITE only; done and err shall never be high together.
REQ-024 Latency: start sampled at edge k; first READ in cycle k+1; done high in cycle k+2*len+1; each word costs exactly 2 cycles.
REQ-025 Copy order shall be strictly ascending word by word; overlapping ranges produce the result of that ascending order (dst>src overlap replicates the leading words), with no detection.
REQ-026 start asserted while not in IDLE shall be ignored and not queued.
REQ-027 In IDLE, DONE and ERR: mem_we=0, mem_addr=0.

Reset
REQ-028 rst=1 shall immediately (without waiting for clk) force IDLE, busy=0, done=0, err=0, mem_we=0, mem_addr=0, mem_data high-Z, and clear the buffer and the counters.
REQ-029 rst asserted mid-transfer shall abort it; words already written remain, no done pulse is produced, and the next start after rst deasserts shall be accepted normally.

Verification
REQ-030 Preload RAM words at 0x000..0x00C with 0x11,0x22,0x33,0x44; start src=0x000 dst=0x100 len=4 -> done in cycle k+9, RAM 0x100..0x10C = 0x11..0x44, exactly 4 write strobes seen.
REQ-031 start src=0x002 dst=0x100 len=1; separately len=0; separately src=0x3FC len=2 -> err pulse one cycle after each, mem_we never 1, RAM unchanged.
REQ-032 start src=0x000 dst=0x3FC len=1 (last legal word) -> accepted, RAM[0x3FC]=RAM[0x000], done at k+3.
REQ-033 Overlap src=0x000 dst=0x004 len=3 with RAM 0x000..0x008 = A,B,C -> RAM 0x004..0x00C = A,A,A.
REQ-034 Assert rst asynchronously in the second WRITE of a len=8 transfer -> bus released and busy=0 before the next edge, no done; a following len=1 request completes with done at k+3.
REQ-035 Pulse start during busy with different arguments -> ignored; the original transfer completes unchanged with a single done pulse.
